// File: rtl/dma_cmd_sequencer_if.sv
// rtl/dma_cmd_sequencer_if.sv - descriptor, DMA CSR and completion signals of the DMA command sequencer
// master is the sequencer side; slave is the host/DMA side.
interface dma_cmd_sequencer_if #(
    parameter int ADDR_WIDTH = 48,
    parameter int LEN_WIDTH  = 24,
    parameter int ID_WIDTH   = 4,
    parameter int DEPTH      = 4
);
    logic                    desc_valid;
    logic                    desc_ready;
    logic [ADDR_WIDTH-1:0]   desc_src;
    logic [ADDR_WIDTH-1:0]   desc_dst;
    logic [LEN_WIDTH-1:0]    desc_len;
    logic [7:0]              desc_burst;
    logic [ID_WIDTH-1:0]     desc_id;
    logic                    flush;
    logic                    dma_csr_wr_en;
    logic [5:0]              dma_csr_addr;
    logic [63:0]             dma_csr_wdata;
    logic                    dma_start;
    logic                    dma_busy;
    logic                    dma_done;
    logic [$clog2(DEPTH):0]  q_level;
    logic                    cmpl_valid;
    logic [ID_WIDTH-1:0]     cmpl_id;
    logic                    cmpl_err;

    modport master (
        input  desc_valid, desc_src, desc_dst, desc_len, desc_burst, desc_id, flush,
        input  dma_busy, dma_done,
        output desc_ready, dma_csr_wr_en, dma_csr_addr, dma_csr_wdata, dma_start,
        output q_level, cmpl_valid, cmpl_id, cmpl_err
    );

    modport slave (
        output desc_valid, desc_src, desc_dst, desc_len, desc_burst, desc_id, flush,
        output dma_busy, dma_done,
        input  desc_ready, dma_csr_wr_en, dma_csr_addr, dma_csr_wdata, dma_start,
        input  q_level, cmpl_valid, cmpl_id, cmpl_err
    );
endinterface

// File: rtl/dma_cmd_sequencer.sv
// rtl/dma_cmd_sequencer.sv - descriptor FIFO that programs the DMA CSR bank, starts it and reports completion
// One descriptor in flight at a time; zero-length descriptors complete with err and never touch the DMA.
module dma_cmd_sequencer #(
    parameter int ADDR_WIDTH = 48,
    parameter int LEN_WIDTH  = 24,
    parameter int ID_WIDTH   = 4,
    parameter int DEPTH      = 4
) (
    input  logic                 clk,
    input  logic                 rst_b,
    dma_cmd_sequencer_if.master  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef enum logic [3:0] {
        IDLE, WR_SRC, WR_DST, WR_LEN, WR_BURST, WR_AUTO, START, WAIT_DONE, CMPL
    } state_t;

    state_t r_state;

    logic [ADDR_WIDTH-1:0] r_q_src   [DEPTH];
    logic [ADDR_WIDTH-1:0] r_q_dst   [DEPTH];
    logic [LEN_WIDTH-1:0]  r_q_len   [DEPTH];
    logic [7:0]            r_q_burst [DEPTH];
    logic [ID_WIDTH-1:0]   r_q_id    [DEPTH];

    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [PW:0]           r_level;

    logic [ADDR_WIDTH-1:0] r_dst;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [7:0]            r_burst;
    logic [ID_WIDTH-1:0]   r_id;

    logic w_push;
    logic w_pop;

    assign bus.desc_ready = (r_level != FULL);
    assign bus.q_level    = r_level;

    // flush wins over a simultaneous push; the pop is already blocked by flush.
    assign w_push = bus.desc_valid && bus.desc_ready && !bus.flush;
    assign w_pop  = (r_state == IDLE) && (r_level != '0) && !bus.flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_src[r_wr_ptr]   <= bus.desc_src;
            r_q_dst[r_wr_ptr]   <= bus.desc_dst;
            r_q_len[r_wr_ptr]   <= bus.desc_len;
            r_q_burst[r_wr_ptr] <= bus.desc_burst;
            r_q_id[r_wr_ptr]    <= bus.desc_id;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (bus.flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (PW+1)'(1);
                2'b01:   r_level <= r_level - (PW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state           <= IDLE;
            r_dst             <= '0;
            r_len             <= '0;
            r_burst           <= '0;
            r_id              <= '0;
            bus.dma_csr_wr_en <= 1'b0;
            bus.dma_csr_addr  <= '0;
            bus.dma_csr_wdata <= '0;
            bus.dma_start     <= 1'b0;
            bus.cmpl_valid    <= 1'b0;
            bus.cmpl_id       <= '0;
            bus.cmpl_err      <= 1'b0;
        end else begin
            bus.dma_csr_wr_en <= 1'b0;
            bus.dma_start     <= 1'b0;
            bus.cmpl_valid    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_dst   <= r_q_dst[r_rd_ptr];
                        r_len   <= r_q_len[r_rd_ptr];
                        r_burst <= r_q_burst[r_rd_ptr];
                        r_id    <= r_q_id[r_rd_ptr];
                        if (r_q_len[r_rd_ptr] == '0) begin
                            bus.cmpl_valid <= 1'b1;
                            bus.cmpl_id    <= r_q_id[r_rd_ptr];
                            bus.cmpl_err   <= 1'b1;
                            r_state        <= CMPL;
                        end else begin
                            bus.dma_csr_wr_en <= 1'b1;
                            bus.dma_csr_addr  <= 6'h00;
                            bus.dma_csr_wdata <= 64'(r_q_src[r_rd_ptr]);
                            r_state           <= WR_SRC;
                        end
                    end
                end
                WR_SRC: begin
                    bus.dma_csr_wr_en <= 1'b1;
                    bus.dma_csr_addr  <= 6'h01;
                    bus.dma_csr_wdata <= 64'(r_dst);
                    r_state           <= WR_DST;
                end
                WR_DST: begin
                    bus.dma_csr_wr_en <= 1'b1;
                    bus.dma_csr_addr  <= 6'h02;
                    bus.dma_csr_wdata <= 64'(r_len);
                    r_state           <= WR_LEN;
                end
                WR_LEN: begin
                    bus.dma_csr_wr_en <= 1'b1;
                    bus.dma_csr_addr  <= 6'h03;
                    bus.dma_csr_wdata <= 64'(r_burst);
                    r_state           <= WR_BURST;
                end
                WR_BURST: begin
                    // auto_restart is always cleared so each descriptor runs exactly once.
                    bus.dma_csr_wr_en <= 1'b1;
                    bus.dma_csr_addr  <= 6'h04;
                    bus.dma_csr_wdata <= '0;
                    r_state           <= WR_AUTO;
                end
                WR_AUTO: begin
                    bus.dma_start <= 1'b1;
                    r_state       <= START;
                end
                START: r_state <= WAIT_DONE;
                WAIT_DONE: begin
                    if (bus.dma_done) begin
                        bus.cmpl_valid <= 1'b1;
                        bus.cmpl_id    <= r_id;
                        bus.cmpl_err   <= 1'b0;
                        r_state        <= CMPL;
                    end
                end
                CMPL:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_cmd_sequencer.sv
// tb/tb_dma_cmd_sequencer.sv - randomized bench for dma_cmd_sequencer against a transaction-schedule model
// The model tracks the descriptor queue and, for the in-flight descriptor, the cycle offsets of its CSR writes/start/completion.
module tb_dma_cmd_sequencer;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [47:0] src;
        logic [47:0] dst;
        logic [23:0] len;
        logic [7:0]  burst;
        logic [3:0]  id;
    } desc_t;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    dma_cmd_sequencer_if bus();
    dma_cmd_sequencer dut (.clk(clk), .rst_b(rst_b), .bus(bus));

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    desc_t mq[$];
    desc_t cur;
    bit    inflight = 0;
    int    pop_edge = 0;
    int    free_edge = 0;

    bit          exp_wr, exp_start, exp_cmpl, exp_err;
    logic [5:0]  exp_addr;
    logic [63:0] exp_data;
    logic [3:0]  exp_id;

    bit hold = 0;
    bit spur_en = 0;
    bit owe = 0;
    int dcnt = 0;
    int dly = 3;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [63:0] csr_data(input desc_t d, input int k);
        case (k)
            0:       return 64'(d.src);
            1:       return 64'(d.dst);
            2:       return 64'(d.len);
            3:       return 64'(d.burst);
            default: return 64'd0;
        endcase
    endfunction

    task automatic model_edge(input bit v, input desc_t d, input bit fl, input bit dn);
        bit acc;
        int k;
        acc = v && (mq.size() != DEPTH);
        exp_wr = 0; exp_start = 0; exp_cmpl = 0;
        if (inflight) begin
            k = cyc - pop_edge;
            if (k <= 4) begin
                exp_wr = 1; exp_addr = 6'(k); exp_data = csr_data(cur, k);
            end else if (k == 5) begin
                exp_start = 1;
            end else if (k >= 7 && dn) begin
                exp_cmpl = 1; exp_id = cur.id; exp_err = 0;
                inflight = 0; free_edge = cyc + 2;
            end
        end
        if (!inflight && cyc >= free_edge && mq.size() != 0 && !fl) begin
            cur = mq.pop_front();
            pop_edge = cyc;
            if (cur.len == 0) begin
                exp_cmpl = 1; exp_id = cur.id; exp_err = 1; free_edge = cyc + 2;
            end else begin
                inflight = 1; exp_wr = 1; exp_addr = 6'd0; exp_data = 64'(cur.src);
            end
        end
        if (fl) mq.delete();
        else if (acc) mq.push_back(d);
    endtask

    task automatic check_outputs();
        check("csr_wr_en", 64'(bus.dma_csr_wr_en), 64'(exp_wr));
        if (exp_wr) begin
            check("csr_addr", 64'(bus.dma_csr_addr), 64'(exp_addr));
            check("csr_wdata", bus.dma_csr_wdata, exp_data);
        end
        check("dma_start", 64'(bus.dma_start), 64'(exp_start));
        check("cmpl_valid", 64'(bus.cmpl_valid), 64'(exp_cmpl));
        if (exp_cmpl) begin
            check("cmpl_id", 64'(bus.cmpl_id), 64'(exp_id));
            check("cmpl_err", 64'(bus.cmpl_err), 64'(exp_err));
        end
        check("q_level", 64'(bus.q_level), 64'(mq.size()));
        check("desc_ready", 64'(bus.desc_ready), 64'(mq.size() != DEPTH));
    endtask

    task automatic step();
        desc_t d;
        bit v, fl, dn;
        @(posedge clk);
        v = bus.desc_valid; fl = bus.flush; dn = bus.dma_done;
        d.src = bus.desc_src; d.dst = bus.desc_dst; d.len = bus.desc_len;
        d.burst = bus.desc_burst; d.id = bus.desc_id;
        cyc++;
        model_edge(v, d, fl, dn);
        #1;
        check_outputs();
        // DMA responder: done a programmable number of cycles after start, optional spurious done
        if (bus.dma_start) begin owe = 1; dcnt = dly; end
        bus.dma_done = 1'b0;
        if (owe && !hold) begin
            if (dcnt <= 0) begin bus.dma_done = 1'b1; owe = 0; end
            else dcnt--;
        end else if (!owe && spur_en && $urandom_range(0, 15) == 0) begin
            bus.dma_done = 1'b1;
        end
        bus.dma_busy = owe;
    endtask

    task automatic drive(input desc_t d);
        bus.desc_src = d.src; bus.desc_dst = d.dst; bus.desc_len = d.len;
        bus.desc_burst = d.burst; bus.desc_id = d.id;
    endtask

    task automatic push_one(input desc_t d);
        bit acc;
        int budget;
        drive(d);
        bus.desc_valid = 1'b1;
        budget = 200;
        acc = 0;
        while (!acc && budget > 0) begin
            acc = (mq.size() != DEPTH) && !bus.flush;
            step();
            budget--;
        end
        if (!acc) check("push_timeout", 64'd1, 64'd0);
        bus.desc_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        while ((inflight || mq.size() != 0 || cyc < free_edge || owe) && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) check("drain_timeout", 64'd1, 64'd0);
    endtask

    function automatic desc_t mk(input logic [47:0] s, input logic [47:0] t, input logic [23:0] l,
                                 input logic [7:0] b, input logic [3:0] i);
        desc_t d;
        d.src = s; d.dst = t; d.len = l; d.burst = b; d.id = i;
        return d;
    endfunction

    function automatic desc_t rnd_desc();
        desc_t d;
        d.src = {$urandom(), $urandom()};
        d.dst = {$urandom(), $urandom()};
        d.len = ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom_range(1, 24'hFFFFFF));
        d.burst = 8'($urandom());
        d.id = 4'($urandom());
        return d;
    endfunction

    task automatic check_all_zero(input string pfx);
        check({pfx, "_ready"}, 64'(bus.desc_ready), 64'd1);
        check({pfx, "_wr_en"}, 64'(bus.dma_csr_wr_en), 64'd0);
        check({pfx, "_addr"}, 64'(bus.dma_csr_addr), 64'd0);
        check({pfx, "_wdata"}, bus.dma_csr_wdata, 64'd0);
        check({pfx, "_start"}, 64'(bus.dma_start), 64'd0);
        check({pfx, "_level"}, 64'(bus.q_level), 64'd0);
        check({pfx, "_cmpl"}, 64'({bus.cmpl_valid, bus.cmpl_id, bus.cmpl_err}), 64'd0);
    endtask

    initial begin
        bus.desc_valid = 0; bus.flush = 0; bus.dma_done = 0; bus.dma_busy = 0;
        drive(mk(48'd0, 48'd0, 24'd0, 8'd0, 4'd0));
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("rst");
        rst_b = 1'b1;

        // single descriptor
        dly = 3;
        push_one(mk(48'h1000, 48'h2000, 24'd32, 8'd15, 4'd3));
        wait_idle(100);

        // zero length
        push_one(mk(48'h5, 48'h6, 24'd0, 8'd1, 4'd7));
        wait_idle(50);

        // back-to-back in-order completion
        for (int i = 1; i <= 3; i++) push_one(mk(48'(i * 48'h100), 48'(i * 48'h300), 24'(i + 4), 8'(i), 4'(i)));
        wait_idle(200);

        // fill while the DMA withholds done
        hold = 1;
        for (int i = 0; i < 5; i++) push_one(mk(48'(i), 48'(i + 10), 24'(i + 1), 8'd3, 4'(8 + i)));
        repeat (3) step();
        check("fill_level", 64'(bus.q_level), 64'd4);
        check("fill_ready", 64'(bus.desc_ready), 64'd0);
        drive(mk(48'hABC, 48'hDEF, 24'd9, 8'd2, 4'd13));
        bus.desc_valid = 1'b1;
        repeat (3) step();
        hold = 0;
        push_one(mk(48'hABC, 48'hDEF, 24'd9, 8'd2, 4'd13));
        wait_idle(400);

        // flush while one descriptor waits for done and two are queued
        hold = 1;
        for (int i = 0; i < 3; i++) push_one(mk(48'(i + 50), 48'(i + 60), 24'd4, 8'd0, 4'(i + 4)));
        repeat (10) step();
        check("pre_flush_level", 64'(bus.q_level), 64'd2);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("flush_level", 64'(bus.q_level), 64'd0);
        hold = 0;
        wait_idle(100);

        // randomized traffic with flushes and spurious done pulses
        spur_en = 1;
        for (int i = 0; i < 600; i++) begin
            drive(rnd_desc());
            bus.desc_valid = ($urandom_range(0, 2) != 0);
            bus.flush = ($urandom_range(0, 40) == 0);
            dly = $urandom_range(1, 6);
            step();
        end
        bus.desc_valid = 1'b0; bus.flush = 1'b0;
        wait_idle(600);
        spur_en = 0;

        // spurious done in IDLE, then async reset while writing len
        bus.dma_done = 1'b1;
        step();
        push_one(mk(48'h77, 48'h88, 24'd5, 8'd1, 4'd9));
        for (int b = 0; b < 20 && !(inflight && cyc - pop_edge == 2); b++) step();
        check("reached_wr_len", 64'(inflight && cyc - pop_edge == 2), 64'd1);
        #2 rst_b = 1'b0;
        #1 check_all_zero("arst");
        mq.delete(); inflight = 0; free_edge = 0; owe = 0;
        bus.dma_done = 1'b0; bus.dma_busy = 1'b0;
        @(posedge clk);
        #1 check_all_zero("arst_hold");
        rst_b = 1'b1;
        push_one(mk(48'h123, 48'h456, 24'd2, 8'd0, 4'd11));
        wait_idle(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
